// File: rtl/pid_lock_sequencer.sv
// pid_lock_sequencer: triangle sweep, capture, PID hand-off and lock qualification.
// Optional HOLD-on-loss behaviour is compiled in with `define PID_LOCK_HOLD_EN.
module pid_lock_sequencer #(
    parameter int ADC_RES = 14,
    parameter int CNT_W   = 24
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic signed [ADC_RES-1:0] dat_i,
    input  logic signed [ADC_RES-1:0] set_sp_i,
    input  logic signed [ADC_RES-1:0] pid_dat_i,
    input  logic signed [ADC_RES-1:0] sweep_min_i,
    input  logic signed [ADC_RES-1:0] sweep_max_i,
    input  logic        [ADC_RES-1:0] sweep_step_i,
    input  logic        [15:0]        sweep_div_i,
    input  logic        [ADC_RES-1:0] lock_thr_i,
    input  logic        [CNT_W-1:0]   lock_cnt_i,
    input  logic        [CNT_W-1:0]   unlock_cnt_i,
    output logic signed [ADC_RES-1:0] dat_o,
    output logic                      int_rst_o,
    output logic                      int_hold_o,
    output logic                      locked_o,
    output logic        [2:0]         state_o,
    output logic        [7:0]         relock_cnt_o
);

    localparam int W = ADC_RES + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SWEEP  = 3'd1,
        S_ACQ    = 3'd2,
        S_LOCKED = 3'd3
`ifdef PID_LOCK_HOLD_EN
        , S_HOLD = 3'd4
`endif
    } state_t;

    state_t             r_state;
    logic [ADC_RES-1:0] r_ramp;
    logic               r_dir;
    logic [15:0]        r_div;
    logic [ADC_RES-1:0] r_off;
    logic [CNT_W-1:0]   r_in_cnt;
    logic [CNT_W-1:0]   r_out_cnt;
    logic [7:0]         r_relock;
    logic               r_in_win;
    logic [ADC_RES-1:0] r_dat;
    logic               r_int_rst;
    logic               r_locked;

    state_t             w_state_nxt;
    logic [ADC_RES-1:0] w_ramp_nxt;
    logic               w_dir_nxt;
    logic [15:0]        w_div_nxt;
    logic [ADC_RES-1:0] w_off_nxt;
    logic [CNT_W-1:0]   w_in_nxt;
    logic [CNT_W-1:0]   w_out_nxt;
    logic               w_relock_inc;
    logic [ADC_RES-1:0] w_dat_nxt;
    logic               w_int_rst_nxt;
    logic               w_locked_nxt;

    logic [W-1:0]       w_sp_x;
    logic [W-1:0]       w_dat_x;
    logic [W-1:0]       w_err;
    logic [W-1:0]       w_abs;
    logic               w_in_win;

    logic [W-1:0]       w_ramp_x;
    logic [W-1:0]       w_min_x;
    logic [W-1:0]       w_max_x;
    logic [W-1:0]       w_up;
    logic [W-1:0]       w_dn;
    logic [ADC_RES-1:0] w_ramp_step;
    logic               w_dir_step;

    logic [W-1:0]       w_sum;
    logic [ADC_RES-1:0] w_sat;

    logic [CNT_W:0]     w_in_inc;
    logic [CNT_W:0]     w_out_inc;
    logic               w_lock_hit;
    logic               w_unlock_hit;

    // Error is one bit wider than the inputs, so its magnitude never overflows.
    assign w_sp_x   = {set_sp_i[ADC_RES-1], set_sp_i};
    assign w_dat_x  = {dat_i[ADC_RES-1], dat_i};
    assign w_err    = w_sp_x - w_dat_x;
    assign w_abs    = w_err[W-1] ? (-w_err) : w_err;
    assign w_in_win = (w_abs <= {1'b0, lock_thr_i});

    assign w_ramp_x = {r_ramp[ADC_RES-1], r_ramp};
    assign w_min_x  = {sweep_min_i[ADC_RES-1], sweep_min_i};
    assign w_max_x  = {sweep_max_i[ADC_RES-1], sweep_max_i};
    assign w_up     = w_ramp_x + {1'b0, sweep_step_i};
    assign w_dn     = w_ramp_x - {1'b0, sweep_step_i};

    always_comb begin
        w_ramp_step = r_ramp;
        w_dir_step  = r_dir;
        if (sweep_step_i == '0 || sweep_min_i >= sweep_max_i) begin
            w_ramp_step = sweep_min_i;
            w_dir_step  = 1'b0;
        end else if (!r_dir) begin
            if ($signed(w_up) > $signed(w_max_x)) begin
                w_ramp_step = sweep_max_i;
                w_dir_step  = 1'b1;
            end else begin
                w_ramp_step = w_up[ADC_RES-1:0];
            end
        end else begin
            if ($signed(w_dn) < $signed(w_min_x)) begin
                w_ramp_step = sweep_min_i;
                w_dir_step  = 1'b0;
            end else begin
                w_ramp_step = w_dn[ADC_RES-1:0];
            end
        end
    end

    assign w_in_inc     = {1'b0, r_in_cnt} + (CNT_W + 1)'(1);
    assign w_out_inc    = {1'b0, r_out_cnt} + (CNT_W + 1)'(1);
    assign w_lock_hit   = (lock_cnt_i == '0)
                        || (r_in_win && (w_in_inc >= {1'b0, lock_cnt_i}));
    assign w_unlock_hit = !r_in_win
                        && (w_out_inc >= {1'b0, unlock_cnt_i});

    always_comb begin
        w_state_nxt  = r_state;
        w_ramp_nxt   = r_ramp;
        w_dir_nxt    = r_dir;
        w_div_nxt    = r_div;
        w_off_nxt    = r_off;
        w_in_nxt     = r_in_cnt;
        w_out_nxt    = r_out_cnt;
        w_relock_inc = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (enable_i) begin
                    w_state_nxt = S_SWEEP;
                    w_ramp_nxt  = sweep_min_i;
                    w_dir_nxt   = 1'b0;
                end
            end
            S_SWEEP: begin
                if (r_in_win) begin
                    w_state_nxt = S_ACQ;
                    w_off_nxt   = r_ramp;
                end else if (r_div == sweep_div_i) begin
                    w_div_nxt  = '0;
                    w_ramp_nxt = w_ramp_step;
                    w_dir_nxt  = w_dir_step;
                end else begin
                    w_div_nxt = r_div + 16'd1;
                end
            end
`ifdef PID_LOCK_HOLD_EN
            S_ACQ, S_HOLD: begin
`else
            S_ACQ: begin
`endif
                w_in_nxt  = r_in_win ? w_in_inc[CNT_W-1:0] : '0;
                w_out_nxt = r_in_win ? '0 : w_out_inc[CNT_W-1:0];
                if (w_lock_hit) begin
                    w_state_nxt = S_LOCKED;
                end else if (w_unlock_hit) begin
                    w_state_nxt  = S_SWEEP;
                    w_ramp_nxt   = r_off;
                    w_relock_inc = 1'b1;
                end
            end
            S_LOCKED: begin
                w_out_nxt = r_in_win ? '0 : w_out_inc[CNT_W-1:0];
                if (w_unlock_hit) begin
`ifdef PID_LOCK_HOLD_EN
                    w_state_nxt  = S_HOLD;
`else
                    w_state_nxt  = S_SWEEP;
                    w_ramp_nxt   = r_off;
                    w_relock_inc = 1'b1;
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (!enable_i) begin
            w_state_nxt  = S_IDLE;
            w_relock_inc = 1'b0;
        end
        if (w_state_nxt != r_state) begin
            w_in_nxt  = '0;
            w_out_nxt = '0;
            w_div_nxt = '0;
        end
    end

    // PID path uses the offset being captured this cycle, so the hand-off is seamless.
    assign w_sum = {w_off_nxt[ADC_RES-1], w_off_nxt}
                 + {pid_dat_i[ADC_RES-1], pid_dat_i};

    always_comb begin
        w_sat = w_sum[ADC_RES-1:0];
        if (w_sum[W-1] != w_sum[W-2]) begin
            w_sat = w_sum[W-1] ? {1'b1, {(ADC_RES-1){1'b0}}}
                               : {1'b0, {(ADC_RES-1){1'b1}}};
        end
    end

`ifdef PID_LOCK_HOLD_EN
    logic r_int_hold;
    logic w_int_hold_nxt;
`endif

    always_comb begin
        w_dat_nxt     = r_dat;
        w_int_rst_nxt = 1'b1;
        w_locked_nxt  = 1'b0;
`ifdef PID_LOCK_HOLD_EN
        w_int_hold_nxt = 1'b0;
`endif
        unique case (w_state_nxt)
            S_IDLE:  w_dat_nxt = sweep_min_i;
            S_SWEEP: w_dat_nxt = w_ramp_nxt;
            S_ACQ: begin
                w_dat_nxt     = w_sat;
                w_int_rst_nxt = 1'b0;
            end
            S_LOCKED: begin
                w_dat_nxt     = w_sat;
                w_int_rst_nxt = 1'b0;
                w_locked_nxt  = 1'b1;
            end
`ifdef PID_LOCK_HOLD_EN
            S_HOLD: begin
                w_int_rst_nxt  = 1'b0;
                w_int_hold_nxt = 1'b1;
            end
`endif
            default: w_dat_nxt = sweep_min_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_ramp    <= '0;
            r_dir     <= 1'b0;
            r_div     <= '0;
            r_off     <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_relock  <= '0;
            r_in_win  <= 1'b0;
            r_dat     <= '0;
            r_int_rst <= 1'b1;
            r_locked  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ramp    <= w_ramp_nxt;
            r_dir     <= w_dir_nxt;
            r_div     <= w_div_nxt;
            r_off     <= w_off_nxt;
            r_in_cnt  <= w_in_nxt;
            r_out_cnt <= w_out_nxt;
            r_in_win  <= w_in_win;
            r_dat     <= w_dat_nxt;
            r_int_rst <= w_int_rst_nxt;
            r_locked  <= w_locked_nxt;
            if (w_relock_inc && r_relock != 8'hFF) begin
                r_relock <= r_relock + 8'd1;
            end
        end
    end

`ifdef PID_LOCK_HOLD_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_int_hold <= 1'b0;
        end else begin
            r_int_hold <= w_int_hold_nxt;
        end
    end

    assign int_hold_o = r_int_hold;
`else
    assign int_hold_o = 1'b0;
`endif

    assign dat_o        = r_dat;
    assign int_rst_o    = r_int_rst;
    assign locked_o     = r_locked;
    assign state_o      = r_state;
    assign relock_cnt_o = r_relock;

endmodule
